// File: rtl/mp_add_sequencer.sv
// mp_add_sequencer: multi-precision add/sub over WORDS 16-bit limbs,
// one limb per clock through a single shared 16-bit adder.
//
// Ports:
//   clk, rst       clock, async active-high reset
//   start          request, sampled only when ready
//   op_sub         0 = a+b, 1 = a-b (needs MP_ADD_SUB_EN)
//   a_in, b_in     operands, 16*WORDS bits, latched on start
//   ready/busy     idle / running indications
//   done           one-cycle completion pulse
//   result         sum/difference, held until next start
//   c_out          carry out of top limb (sub: 1 = no borrow)
//   overflow       two's-complement overflow
//   zero           result == 0
//
// Build option: define MP_ADD_SUB_EN to honour op_sub.
// Without it the block is add-only and op_sub is ignored.

module mp_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_sub,
  input  logic [16*WORDS-1:0] a_in,
  input  logic [16*WORDS-1:0] b_in,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [16*WORDS-1:0] result,
  output logic              c_out,
  output logic              overflow,
  output logic              zero
);

  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WORDS-1:0][15:0] a_q;
  logic [WORDS-1:0][15:0] b_q;
  logic [WORDS-1:0][15:0] res_q;
  logic [IW-1:0]          idx;
  logic                   carry_reg;
  logic                   zero_acc;

  logic [16*WORDS-1:0] b_lat;
  logic                cin0;

`ifdef MP_ADD_SUB_EN
  // a - b == a + ~b + 1
  assign b_lat = op_sub ? ~b_in : b_in;
  assign cin0  = op_sub;
`else
  logic op_sub_unused;
  assign op_sub_unused = op_sub;
  assign b_lat = b_in;
  assign cin0  = 1'b0;
`endif

  // Shared 16-bit adder slice
  logic [15:0] add_a, add_b, add_s;
  logic        add_co;
  logic        s_zero;

  assign add_a = a_q[idx];
  assign add_b = b_q[idx];
  assign {add_co, add_s} = {1'b0, add_a}
                         + {1'b0, add_b}
                         + {16'd0, carry_reg};
  assign s_zero = (add_s == 16'd0);

  logic last;
  logic accept;
  logic run;

  assign last   = (idx == IW'(WORDS - 1));
  assign accept = (state == IDLE) && start;
  assign run    = (state == RUN);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      zero_acc  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (1'b1)
        accept: begin
          a_q       <= a_in;
          b_q       <= b_lat;
          carry_reg <= cin0;
          idx       <= '0;
          res_q     <= '0;
          zero_acc  <= 1'b1;
        end
        run: begin
          res_q[idx] <= add_s;
          carry_reg  <= add_co;
          zero_acc   <= zero_acc & s_zero;
          if (last) begin
            c_out    <= add_co;
            // signs of top limb operands agree but sum sign differs
            overflow <= (add_a[15] == add_b[15])
                     && (add_s[15] != add_a[15]);
            zero     <= zero_acc & s_zero;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready  = (state == IDLE);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign result = res_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// tb_mp_add_sequencer: directed checks for mp_add_sequencer
// at WORDS=4 and WORDS=2.

module tb_mp_add_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic        start4 = 1'b0;
  logic        sub4   = 1'b0;
  logic [63:0] a4     = '0;
  logic [63:0] b4     = '0;
  logic        ready4, busy4, done4;
  logic [63:0] result4;
  logic        c_out4, ovf4, zero4;

  logic        start2 = 1'b0;
  logic        sub2   = 1'b0;
  logic [31:0] a2     = '0;
  logic [31:0] b2     = '0;
  logic        ready2, busy2, done2;
  logic [31:0] result2;
  logic        c_out2, ovf2, zero2;

  mp_add_sequencer #(.WORDS(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .start    (start4),
    .op_sub   (sub4),
    .a_in     (a4),
    .b_in     (b4),
    .ready    (ready4),
    .busy     (busy4),
    .done     (done4),
    .result   (result4),
    .c_out    (c_out4),
    .overflow (ovf4),
    .zero     (zero4)
  );

  mp_add_sequencer #(.WORDS(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .start    (start2),
    .op_sub   (sub2),
    .a_in     (a2),
    .b_in     (b2),
    .ready    (ready2),
    .busy     (busy2),
    .done     (done2),
    .result   (result2),
    .c_out    (c_out2),
    .overflow (ovf2),
    .zero     (zero2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One WORDS=4 operation; optional start poke during RUN.
  task automatic run4(input string tag,
                      input logic [63:0] a,
                      input logic [63:0] b,
                      input logic sub,
                      input int poke,
                      input logic [63:0] er,
                      input logic ec,
                      input logic ev,
                      input logic ez);
    int lat, bc, dc;
    logic [63:0] r;
    logic c, v, z;
    lat = 0; bc = 0; dc = 0;
    r = 'x; c = 1'bx; v = 1'bx; z = 1'bx;
    @(negedge clk);
    a4 = a; b4 = b; sub4 = sub; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    a4 = ~a; b4 = ~b; sub4 = ~sub;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == poke) begin
        start4 = 1'b1;
        a4 = 64'h1111_2222_3333_4444;
        b4 = 64'h0101_0101_0101_0101;
      end else begin
        start4 = 1'b0;
      end
      if (busy4) bc++;
      if (done4) begin
        dc++;
        if (lat == 0) begin
          lat = n;
          r = result4; c = c_out4;
          v = ovf4;    z = zero4;
        end
      end
    end
    check({tag, ".lat"},   64'(lat), 64'd5);
    check({tag, ".busy"},  64'(bc),  64'd4);
    check({tag, ".ndone"}, 64'(dc),  64'd1);
    check({tag, ".res"},   r, er);
    check({tag, ".cout"},  64'(c), 64'(ec));
    check({tag, ".ovf"},   64'(v), 64'(ev));
    check({tag, ".zero"},  64'(z), 64'(ez));
    check({tag, ".ready"}, 64'(ready4), 64'd1);
    check({tag, ".hold"},  result4, er);
  endtask

  initial begin
    int dc, lat;
    logic [31:0] r2;

    repeat (2) @(negedge clk);
    check("rst.ready", 64'(ready4),   64'd1);
    check("rst.busy",  64'(busy4),    64'd0);
    check("rst.done",  64'(done4),    64'd0);
    check("rst.res",   result4,       64'd0);
    check("rst.cout",  64'(c_out4),   64'd0);
    check("rst.ovf",   64'(ovf4),     64'd0);
    check("rst.zero",  64'(zero4),    64'd0);
    rst = 1'b0;

    run4("wrap", 64'hFFFF_FFFF_FFFF_FFFF,
         64'h0000_0000_0000_0001, 1'b0, 0,
         64'h0, 1'b1, 1'b0, 1'b1);
    run4("ovf", 64'h7FFF_FFFF_FFFF_FFFF,
         64'h1, 1'b0, 0,
         64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    run4("mix", 64'h1234_5678_9ABC_DEF0,
         64'h0FED_CBA9_8765_4321, 1'b0, 0,
         64'h2222_2222_2222_2211, 1'b0, 1'b0, 1'b0);
    run4("negneg", 64'h8000_0000_0000_0000,
         64'h8000_0000_0000_0000, 1'b0, 0,
         64'h0, 1'b1, 1'b1, 1'b1);
`ifdef MP_ADD_SUB_EN
    run4("sub01", 64'h0, 64'h1, 1'b1, 0,
         64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run4("sub53", 64'h5, 64'h3, 1'b1, 0,
         64'h2, 1'b1, 1'b0, 1'b0);
    run4("subovf", 64'h8000_0000_0000_0000,
         64'h1, 1'b1, 0,
         64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
`else
    run4("sub01", 64'h0, 64'h1, 1'b1, 0,
         64'h1, 1'b0, 1'b0, 1'b0);
    run4("sub53", 64'h5, 64'h3, 1'b1, 0,
         64'h8, 1'b0, 1'b0, 1'b0);
    run4("subovf", 64'h8000_0000_0000_0000,
         64'h1, 1'b1, 0,
         64'h8000_0000_0000_0001, 1'b0, 1'b0, 1'b0);
`endif
    run4("poke", 64'h0000_0000_0001_FFFF,
         64'h0000_0000_0000_0001, 1'b0, 2,
         64'h0000_0000_0002_0000, 1'b0, 1'b0, 1'b0);

    // Abort mid-RUN with reset
    @(negedge clk);
    a4 = 64'h0001_0001_0001_0001;
    b4 = 64'h0001_0001_0001_0001;
    sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    repeat (2) @(negedge clk);
    check("abort.part", result4, 64'h2);
    rst = 1'b1;
    #1;
    check("abort.ready", 64'(ready4), 64'd1);
    check("abort.busy",  64'(busy4),  64'd0);
    check("abort.done",  64'(done4),  64'd0);
    check("abort.res",   result4,     64'd0);
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) dc++;
    end
    check("abort.nodone", 64'(dc), 64'd0);
    run4("after", 64'h0001_0001_0001_0001,
         64'h0001_0001_0001_0001, 1'b0, 0,
         64'h0002_0002_0002_0002, 1'b0, 1'b0, 1'b0);

    // WORDS=2 carry chain
    @(negedge clk);
    a2 = 32'h0001_FFFF; b2 = 32'h0000_0001;
    sub2 = 1'b0; start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    lat = 0; r2 = 'x;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (done2 && lat == 0) begin
        lat = n;
        r2 = result2;
      end
    end
    check("w2.lat",  64'(lat), 64'd3);
    check("w2.res",  64'(r2),  64'h0002_0000);
    check("w2.cout", 64'(c_out2), 64'd0);
    check("w2.ovf",  64'(ovf2),   64'd0);
    check("w2.zero", 64'(zero2),  64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
